axi_decerr_slave: RTL and testbench

//  AXI4 responder that terminates every transaction the SoC crossbar cannot map to any

---
 rtl/axi_decerr_slave_pkg.sv | 9 +
 rtl/axi_decerr_rd_chan.sv | 72 +++++++
 rtl/axi_decerr_slave.sv | 123 ++++++++++++
 tb/tb_axi_decerr_slave.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_decerr_slave_pkg.sv
// Shared constants for the default (decode-error) crossbar slave.
// Holds the SoC-wide slave ID width and the fixed error response values.
package axi_decerr_slave_pkg;

  localparam int          IdWidthSlave  = 5;
  localparam logic [1:0]  AxiRespDecErr = 2'b11;
  localparam logic [63:0] ErrRespData   = 64'hDEAD_BEEF_DEAD_BEEF;

endpackage

// File: rtl/axi_decerr_rd_chan.sv
// Read half of the decode-error slave.
// Accepts one AR, then streams ARLEN+1 error beats.
module axi_decerr_rd_chan
  import axi_decerr_slave_pkg::*;
#(
  parameter int IdWidth = IdWidthSlave
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IdWidth-1:0] ar_id_i,
  input  logic [7:0]         ar_len_i,
  input  logic               ar_valid_i,
  output logic               ar_ready_o,
  output logic [IdWidth-1:0] r_id_o,
  output logic               r_last_o,
  output logic               r_valid_o,
  input  logic               r_ready_i
);

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  r_state_e           state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IdWidth-1:0] id_q, id_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= R_IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
    end
  end

  // Counter holds beats remaining after the current one.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_last_o   = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) begin
          id_d    = ar_id_i;
          cnt_d   = ar_len_i;
          state_d = R_DATA;
        end
      end
      R_DATA: begin
        r_valid_o = 1'b1;
        r_last_o  = (cnt_q == 8'd0);
        if (r_ready_i) begin
          if (cnt_q == 8'd0) state_d = R_IDLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign r_id_o = id_q;

endmodule

// File: rtl/axi_decerr_slave.sv
// Default crossbar slave: answers every unmapped access with DECERR
// and records the first faulting address for software.
module axi_decerr_slave
  import axi_decerr_slave_pkg::*;
#(
  parameter int                   IdWidth   = IdWidthSlave,
  parameter int                   AddrWidth = 64,
  parameter int                   DataWidth = 64,
  parameter logic [DataWidth-1:0] RespData  = ErrRespData
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic                 w_last_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic                 err_valid_o,
  input  logic                 err_clr_i
);

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  w_state_e           w_state_q, w_state_d;
  logic [IdWidth-1:0] b_id_q, b_id_d;
  logic               aw_hs, ar_hs;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      b_id_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      b_id_q    <= b_id_d;
    end
  end

  always_comb begin
    w_state_d  = w_state_q;
    b_id_d     = b_id_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) begin
          b_id_d    = aw_id_i;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready_o = 1'b1;
        if (w_valid_i && w_last_i) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign b_id_o   = b_id_q;
  assign b_resp_o = AxiRespDecErr;

  axi_decerr_rd_chan #(
    .IdWidth (IdWidth)
  ) u_rd_chan (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ar_id_i    (ar_id_i),
    .ar_len_i   (ar_len_i),
    .ar_valid_i (ar_valid_i),
    .ar_ready_o (ar_ready_o),
    .r_id_o     (r_id_o),
    .r_last_o   (r_last_o),
    .r_valid_o  (r_valid_o),
    .r_ready_i  (r_ready_i)
  );

  assign r_data_o = RespData;
  assign r_resp_o = AxiRespDecErr;

  assign aw_hs = aw_valid_i & aw_ready_o;
  assign ar_hs = ar_valid_i & ar_ready_o;

  // Clear beats a same-cycle fault; AW address beats AR address.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
    end else if (err_clr_i) begin
      err_valid_o <= 1'b0;
    end else if (!err_valid_o && (aw_hs || ar_hs)) begin
      err_valid_o <= 1'b1;
      err_addr_o  <= aw_hs ? aw_addr_i : ar_addr_i;
    end
  end

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Directed plus randomized checks of the decode-error slave
// against a transaction-level reference model.
module tb_axi_decerr_slave;

  localparam logic [63:0] RDATA = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  aw_id;
  logic [63:0] aw_addr;
  logic        aw_valid, aw_ready;
  logic        w_last, w_valid, w_ready;
  logic [4:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_valid, b_ready;
  logic [4:0]  ar_id;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic        ar_valid, ar_ready;
  logic [4:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last, r_valid, r_ready;
  logic [63:0] err_addr;
  logic        err_valid, err_clr;

  int compared   = 0;
  int mismatched = 0;

  bit          mdl_err_v = 0;
  logic [63:0] mdl_err_a = '0;

  always #5 clk = ~clk;

  axi_decerr_slave dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .aw_id_i     (aw_id),
    .aw_addr_i   (aw_addr),
    .aw_valid_i  (aw_valid),
    .aw_ready_o  (aw_ready),
    .w_last_i    (w_last),
    .w_valid_i   (w_valid),
    .w_ready_o   (w_ready),
    .b_id_o      (b_id),
    .b_resp_o    (b_resp),
    .b_valid_o   (b_valid),
    .b_ready_i   (b_ready),
    .ar_id_i     (ar_id),
    .ar_addr_i   (ar_addr),
    .ar_len_i    (ar_len),
    .ar_valid_i  (ar_valid),
    .ar_ready_o  (ar_ready),
    .r_id_o      (r_id),
    .r_data_o    (r_data),
    .r_resp_o    (r_resp),
    .r_last_o    (r_last),
    .r_valid_o   (r_valid),
    .r_ready_i   (r_ready),
    .err_addr_o  (err_addr),
    .err_valid_o (err_valid),
    .err_clr_i   (err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void fault(input logic [63:0] a);
    if (!mdl_err_v) begin
      mdl_err_v = 1'b1;
      mdl_err_a = a;
    end
  endfunction

  task automatic chk_err();
    chk("err_valid", err_valid, mdl_err_v);
    if (mdl_err_v) chk("err_addr", err_addr, mdl_err_a);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    step();
    err_clr   = 1'b0;
    mdl_err_v = 1'b0;
    chk("err_clr", err_valid, 1'b0);
  endtask

  task automatic do_write(input logic [4:0] id, input logic [63:0] addr,
                          input int nb, input int bdly,
                          input bit early, input bit gap);
    int sent;
    int cyc;
    if (early) begin
      w_valid = 1'b1;
      w_last  = (nb == 1);
      repeat (3) begin
        chk("w_ready_pre_aw", w_ready, 1'b0);
        step();
      end
    end
    aw_id    = id;
    aw_addr  = addr;
    aw_valid = 1'b1;
    chk("aw_ready", aw_ready, 1'b1);
    step();
    aw_valid = 1'b0;
    fault(addr);
    sent = 0;
    cyc  = 0;
    while (sent < nb && cyc < 500) begin
      w_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      w_last  = (sent == nb - 1);
      chk("w_ready", w_ready, 1'b1);
      chk("b_early", b_valid, 1'b0);
      if (w_valid) sent++;
      step();
      cyc++;
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
    chk("w_beats", 64'(sent), 64'(nb));
    for (int i = 0; i <= bdly; i++) begin
      b_ready = (i == bdly);
      chk("b_valid", b_valid, 1'b1);
      chk("b_id", b_id, id);
      chk("b_resp", b_resp, 2'b11);
      step();
    end
    b_ready = 1'b0;
    chk("b_done", b_valid, 1'b0);
    chk("aw_ready_back", aw_ready, 1'b1);
    chk_err();
  endtask

  task automatic do_read(input logic [4:0] id, input logic [63:0] addr,
                         input int len, input int rmode, input bit clr);
    int beats;
    int cyc;
    ar_id    = id;
    ar_addr  = addr;
    ar_len   = 8'(len);
    ar_valid = 1'b1;
    err_clr  = clr;
    chk("ar_ready", ar_ready, 1'b1);
    step();
    ar_valid = 1'b0;
    err_clr  = 1'b0;
    if (clr) mdl_err_v = 1'b0;
    else     fault(addr);
    beats = 0;
    cyc   = 0;
    while (beats <= len && cyc < 2000) begin
      case (rmode)
        0:       r_ready = 1'b1;
        1:       r_ready = 1'($urandom_range(0, 1));
        default: r_ready = cyc[0];
      endcase
      chk("r_valid", r_valid, 1'b1);
      chk("r_id", r_id, id);
      chk("r_data", r_data, RDATA);
      chk("r_resp", r_resp, 2'b11);
      chk("r_last", r_last, (beats == len));
      if (r_ready) beats++;
      step();
      cyc++;
    end
    r_ready = 1'b0;
    chk("r_beats", 64'(beats), 64'(len + 1));
    chk("r_done", r_valid, 1'b0);
    chk("ar_ready_back", ar_ready, 1'b1);
    chk_err();
  endtask

  initial begin
    int  wsent;
    int  rbeats;
    int  cyc;
    bit  bdone;
    rst      = 1'b1;
    aw_id    = '0;
    aw_addr  = '0;
    aw_valid = 1'b0;
    w_last   = 1'b0;
    w_valid  = 1'b0;
    b_ready  = 1'b0;
    ar_id    = '0;
    ar_addr  = '0;
    ar_len   = '0;
    ar_valid = 1'b0;
    r_ready  = 1'b0;
    err_clr  = 1'b0;
    repeat (3) step();

    chk("rst_aw_ready", aw_ready, 1'b1);
    chk("rst_ar_ready", ar_ready, 1'b1);
    chk("rst_w_ready", w_ready, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_r_last", r_last, 1'b0);
    chk("rst_err_valid", err_valid, 1'b0);
    chk("rst_b_id", b_id, 5'd0);
    chk("rst_r_id", r_id, 5'd0);
    chk("rst_err_addr", err_addr, 64'd0);
    rst = 1'b0;
    step();

    do_write(5'd5, 64'h6000_0000, 1, 0, 1'b0, 1'b0);
    clear_err();
    do_read(5'd3, 64'h6100_0000, 3, 0, 1'b0);
    do_read(5'd9, 64'h6200_0000, 0, 2, 1'b0);
    do_read(5'd7, 64'h6300_0000, 255, 1, 1'b0);

    clear_err();
    aw_id    = 5'd1;
    aw_addr  = 64'h7000_0000;
    aw_valid = 1'b1;
    ar_id    = 5'd2;
    ar_addr  = 64'h6800_0000;
    ar_len   = 8'd7;
    ar_valid = 1'b1;
    step();
    aw_valid = 1'b0;
    ar_valid = 1'b0;
    fault(64'h7000_0000);
    fault(64'h6800_0000);
    wsent  = 0;
    rbeats = 0;
    bdone  = 1'b0;
    cyc    = 0;
    while (!(bdone && rbeats == 8) && cyc < 500) begin
      w_valid = (wsent < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      w_last  = (wsent == 7);
      b_ready = 1'($urandom_range(0, 1));
      r_ready = 1'($urandom_range(0, 1));
      if (rbeats < 8) begin
        chk("cc_r_valid", r_valid, 1'b1);
        chk("cc_r_id", r_id, 5'd2);
        chk("cc_r_last", r_last, (rbeats == 7));
      end
      if (wsent < 8) begin
        chk("cc_w_ready", w_ready, 1'b1);
        chk("cc_b_early", b_valid, 1'b0);
      end else if (!bdone) begin
        chk("cc_b_valid", b_valid, 1'b1);
        chk("cc_b_id", b_id, 5'd1);
        if (b_ready) bdone = 1'b1;
      end
      if (w_valid && wsent < 8) wsent++;
      if (r_ready && rbeats < 8) rbeats++;
      step();
      cyc++;
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
    b_ready = 1'b0;
    r_ready = 1'b0;
    chk("cc_b_done", bdone, 1'b1);
    chk("cc_r_beats", 64'(rbeats), 64'd8);
    chk("cc_idle_b", b_valid, 1'b0);
    chk("cc_idle_r", r_valid, 1'b0);
    chk_err();

    do_write(5'd12, 64'h7100_0000, 1, 10, 1'b1, 1'b0);
    do_read(5'd4, 64'h7200_0000, 0, 0, 1'b1);
    do_read(5'd6, 64'h7300_0000, 1, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) clear_err();
      if ($urandom_range(0, 1) == 1)
        do_read(5'($urandom), {$urandom, $urandom},
                int'($urandom_range(0, 15)), 1, 1'b0);
      else
        do_write(5'($urandom), {$urandom, $urandom},
                 int'($urandom_range(1, 4)),
                 int'($urandom_range(0, 3)), 1'b0, 1'b1);
    end

    ar_id    = 5'd8;
    ar_addr  = 64'h7400_0000;
    ar_len   = 8'd7;
    ar_valid = 1'b1;
    step();
    ar_valid = 1'b0;
    r_ready  = 1'b1;
    step();
    chk("mid_r_valid", r_valid, 1'b1);
    chk("mid_r_last", r_last, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_async_r_valid", r_valid, 1'b0);
    chk("rst_async_r_last", r_last, 1'b0);
    r_ready = 1'b0;
    step();
    rst       = 1'b0;
    mdl_err_v = 1'b0;
    step();
    chk("post_rst_ar_ready", ar_ready, 1'b1);
    chk("post_rst_aw_ready", aw_ready, 1'b1);
    chk("post_rst_err_valid", err_valid, 1'b0);
    chk("post_rst_r_valid", r_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
